grid_display_scanner: RTL
=========================

// Module: grid_display_scanner
// PURPOSE
//  Reader/consumer end of the 64-bit generation bus produced by control_logic.
//  Accepts one Game-of-Life grid per frame through a valid/ready handshake.
//  Holds the accepted grid and scans it row by row onto a multiplexed 8x8 LED matrix.
//  Pulses frame_done when a frame completes, so the upstream logic can advance one generation.
// PARAMETERS
//  ROWS       8     matrix rows; grid width is ROWS*COLS bits
//  COLS       8     matrix columns
//  DWELL      1000  clk cycles each row is lit; legal range >= 1
//  BLANK_CYC  2     clk cycles all rows are off between rows (anti-ghosting); legal range >= 0
// PORTS
//  clk         in   1          system clock, all state on posedge
//  reset       in   1          asynchronous, active-low reset
//  grid        in   ROWS*COLS  grid to display; bit r*COLS+c = cell(row r, col c); row 0 = bits [COLS-1:0]
//  grid_valid  in   1          upstream asserts when grid holds a new generation
//  grid_ready  out  1          scanner can accept grid this cycle
//  row_en      out  ROWS       one-hot row drive, active-high; all zero = blanked
//  col_data    out  COLS       column data for the lit row; bit c = cell(row, c)
//  frame_done  out  1          one-cycle pulse at the end of the last row's blank period
//  busy        out  1          high whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset==0, asynchronous):
//      state=IDLE, frame register=0, row=0, dwell_cnt=0.
//      row_en=0, col_data=0, frame_done=0, busy=0.
//      grid_ready=0 while reset is asserted; 1 in the first IDLE cycle after release.
//      Assertion mid-frame aborts the scan immediately; no frame_done is issued.
//  - Transfer: occurs on any clk edge with grid_valid && grid_ready.
//      The frame register captures grid; grid is don't-care otherwise.
//  - State machine IDLE -> SCAN -> BLANK -> (SCAN | IDLE-equivalent wrap):
//    IDLE:  row_en=0, col_data=0, grid_ready=1.
//           On transfer: row=0, dwell_cnt=DWELL-1, go to SCAN. Otherwise stay in IDLE.
//           IDLE is entered only from reset.
//    SCAN:  row_en=1<<row, col_data=frame[row*COLS +: COLS], grid_ready=0.
//           dwell_cnt decrements each cycle. At 0: if BLANK_CYC>0, go to BLANK
//           with blank_cnt=BLANK_CYC-1; otherwise apply the end-of-row rule directly.
//           The row is lit for exactly DWELL cycles.
//    BLANK: row_en=0, col_data=0. blank_cnt decrements each cycle. At 0, apply the end-of-row rule.
//  - End-of-row rule:
//      If row<ROWS-1: row++, reload dwell_cnt, go to SCAN.
//      If row==ROWS-1: frame_done=1 in this cycle and grid_ready=1 in this cycle.
//        With a transfer, the new grid is captured; without one, the held frame is kept.
//        Then row=0 and the FSM goes to SCAN.
//      The display never goes dark between frames.
//  - Ready/done timing:
//      When BLANK_CYC=0, grid_ready and frame_done rise in the last SCAN cycle of row ROWS-1.
//      In that cycle the outputs still show row ROWS-1.
//      frame_done and the wrap-cycle grid_ready are always asserted in the same cycle.
//  - Latency: the transfer edge is followed by row_en=1 (row 0) with the new row-0 data in the next cycle.
//  - Frame period (start of row 0 to start of the next row 0): ROWS*(DWELL+BLANK_CYC) cycles.
//  - A grid_valid held high across frames is accepted once per frame, at the wrap cycle only.
//  - Counters: width $clog2(max(DWELL,BLANK_CYC,ROWS)+1), unsigned; row never exceeds ROWS-1.
//  - No combinational path from grid or grid_valid to any output.
//      grid_ready, row_en, col_data and frame_done depend only on registered state.
// TESTING (bench params ROWS=8, COLS=8, DWELL=4, BLANK_CYC=2)
//  1. Reset, then hold grid_valid=0 for 50 cycles
//       -> row_en=0, col_data=0, grid_ready=1, busy=0, frame_done never asserted.
//  2. Transfer grid=64'h8040_2010_0804_0201
//       -> the next cycle gives row_en=8'h01 with col_data=8'h01 for 4 cycles, then row_en=0 for 2 cycles.
//       -> row 7 then shows col_data=8'h80; frame_done pulses exactly once, 48 cycles after row 0 first lit.
//  3. Do not present a new grid at the wrap
//       -> the second frame repeats the identical row/col sequence; frame_done pulses every 48 cycles.
//  4. Hold grid_valid=1 with a different grid each cycle
//       -> only the value present at the wrap cycle is displayed in the next frame; grid_ready is high 1 cycle per 48.
//  5. Drop reset low mid-row 3, hold 3 cycles, release
//       -> outputs go to 0 asynchronously with no frame_done; back in IDLE, a new transfer restarts from row 0.
//  6. Re-run case 2 with BLANK_CYC=0
//       -> there are no blank gaps; frame_done and grid_ready coincide with the last SCAN cycle of row 7; the period is 32 cycles.

Source files
------------

// File: rtl/grid_display_scanner.sv
// Consumer end of the generation bus: accepts one grid per frame over valid/ready
// and scans it row by row onto a multiplexed LED matrix, pulsing frame_done per frame.
module grid_display_scanner #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROWS*COLS-1:0]   grid,
    input  logic                   grid_valid,
    output logic                   grid_ready,
    output logic [ROWS-1:0]        row_en,
    output logic [COLS-1:0]        col_data,
    output logic                   frame_done,
    output logic                   busy
);

    localparam int MAX_DB  = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int MAX_ALL = (MAX_DB > ROWS) ? MAX_DB : ROWS;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam bit            NO_BLANK   = (BLANK_CYC == 0);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LOAD = NO_BLANK ? '0 : CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] BLANK = 2'd2;

    logic [1:0]           state;
    logic [ROWS*COLS-1:0] frame;
    logic [CW-1:0]        row;
    logic [CW-1:0]        dwell_cnt;
    logic [CW-1:0]        blank_cnt;

    logic last_row;
    logic row_end;
    logic wrap;
    logic transfer;

    // With no blanking the row ends on the last lit cycle, otherwise on the last blank cycle.
    always_comb begin
        last_row = (row == LAST_ROW);
        if (NO_BLANK) begin
            row_end = (state == SCAN) && (dwell_cnt == '0);
        end else begin
            row_end = (state == BLANK) && (blank_cnt == '0);
        end
        wrap       = row_end && last_row;
        grid_ready = ((state == IDLE) && reset) || wrap;
        frame_done = wrap;
        busy       = (state != IDLE);
        transfer   = grid_valid && grid_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            frame     <= '0;
            row       <= '0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
        end else if (row_end) begin
            dwell_cnt <= DWELL_LOAD;
            state     <= SCAN;
            if (last_row) begin
                row <= '0;
                if (transfer) begin
                    frame <= grid;
                end
            end else begin
                row <= row + 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        frame     <= grid;
                        row       <= '0;
                        dwell_cnt <= DWELL_LOAD;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        blank_cnt <= BLANK_LOAD;
                        state     <= BLANK;
                    end
                end
                BLANK: begin
                    blank_cnt <= blank_cnt - 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Row drive and column data are pure decodes of the held frame and row pointer.
    always_comb begin
        row_en   = '0;
        col_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ((state == SCAN) && (row == CW'(r))) begin
                row_en[r] = 1'b1;
                col_data  = frame[r*COLS +: COLS];
            end
        end
    end

endmodule
